// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit/clk).
// start/busy/done handshake; bcd_out and overflow hold until the next done.
// Optional: define BIN2BCD_EX3_OUT_EN to add ex3_out (each digit + 3),
// registered with bcd_out, so the downstream Excess-3 stage can be skipped.

// Per-digit add-3 correction; digit <= 9 in, so the result is at most 12.
module bin_to_bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN2BCD_EX3_OUT_EN
  output logic [4*DIGITS-1:0]   ex3_out,
`endif
  output logic                  overflow
);
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [DIGITS-1:0][3:0]  bcd_work;
  logic [DIGITS-1:0][3:0]  bcd_adj;
  logic [DIGITS-1:0][3:0]  bcd_next;
  logic [BIN_W-1:0]        bin_work;
  logic [CW-1:0]           cnt;
  logic                    ovf_acc;
  logic                    shift_out;

  // All digits corrected in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin_to_bcd_digit u_dig (.d(bcd_work[g]), .q(bcd_adj[g]));
  end

  // One shift step: top digit's MSB falls out, binary MSB enters digit 0.
  assign {shift_out, bcd_next} = {bcd_adj, bin_work[BIN_W-1]};

`ifdef BIN2BCD_EX3_OUT_EN
  logic [DIGITS-1:0][3:0] ex3_next;
  for (genvar g = 0; g < DIGITS; g++) begin : g_ex3
    assign ex3_next[g] = bcd_next[g] + 4'd3;
  end
`endif

  // Control FSM plus datapath; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      bcd_work <= '0;
      bin_work <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
`ifdef BIN2BCD_EX3_OUT_EN
      ex3_out  <= {DIGITS{4'h3}};
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_work <= bin_in;
            bcd_work <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= CW'(BIN_W);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_next;
          bin_work <= bin_work << 1;
          ovf_acc  <= ovf_acc | shift_out;
          cnt      <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= bcd_next;
            overflow <= ovf_acc | shift_out;
`ifdef BIN2BCD_EX3_OUT_EN
            ex3_out  <= ex3_next;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the iterative shift-add-3 (double-dabble) algorithm, one binary bit per clock.
Sits directly upstream of the BCD to Excess-3 stage and supplies it with packed BCD digits.
Uses a start/busy/done handshake. The result is held stable until the next conversion completes.

Parameters:
BIN_W, 8, width of the unsigned binary input; also the number of shift cycles.
DIGITS, 3, number of 4-bit BCD digits in the output.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a conversion; sampled only in IDLE.
bin_in  input  BIN_W  unsigned binary operand; captured at the edge where start is accepted.
busy  output  1  high while a conversion is in progress (state SHIFT).
done  output  1  single-cycle pulse; result valid on bcd_out.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0].
overflow  output  1  set when the result does not fit in DIGITS digits; valid with done.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy, done, overflow = 0; bcd_out = 0.
  - Internal shift register and counter are cleared.
  - Reset mid-conversion abandons the conversion; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When start = 1 at an edge E0: latch bin_in, clear the BCD working register and overflow accumulator, load counter = BIN_W, go to SHIFT.
  - When start = 0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every working digit >= 5 gets +3 (all digits in parallel, 4-bit wrap-free since max is 12).
  - Then shift {bcd_work, bin_work} left by 1.
  - The bit shifted out of the top digit is ORed into the overflow accumulator.
  - Counter decrements. After the BIN_W-th iteration (edge E_BIN_W), go to DONE.
- DONE (entered at edge E_BIN_W):
  - bcd_out and overflow are registered from the working values on that same edge.
  - done = 1 for exactly one cycle.
  - Next edge: done = 0, return to IDLE.
- Latency: done is high during the cycle following edge E_BIN_W, i.e. BIN_W cycles after start is accepted. Throughput is one conversion per BIN_W+2 cycles.
- busy = 1 exactly while in SHIFT (BIN_W cycles).
- start is ignored in SHIFT and DONE; there is no queuing. bin_in changes after capture have no effect.
- bcd_out and overflow hold their last value between conversions; they change only on the edge that enters DONE.
- If start is held high continuously, a new conversion begins on the first edge after DONE returns to IDLE.
- Input 0 yields all-zero digits. Maximum input (2^BIN_W - 1) must convert correctly whenever DIGITS >= ceil(BIN_W * log10(2)).

Optional Feature:
Macro BIN2BCD_EX3_OUT_EN.
- Defined:
  - Adds output port ex3_out (output, 4*DIGITS), each nibble = the corresponding bcd_out nibble + 3.
  - ex3_out is registered on the same edge as bcd_out, so it is valid with done.
  - Reset value is 4'h3 in every nibble.
  - Lets the design bypass the downstream Excess-3 stage.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start with bin_in = 0 -> busy high for 8 cycles, done pulses once, bcd_out = 12'h000, overflow = 0.
2. bin_in = 255 -> bcd_out = 12'h255, done exactly 8 cycles after the start edge; then bin_in = 99 -> 12'h099; then bin_in = 47 -> 12'h047.
3. Start with bin_in = 128; pulse start again and change bin_in to 7 during SHIFT -> second start ignored, result 12'h128, single done.
4. Start with bin_in = 200; assert rst_n low at cycle 4 of SHIFT, release, then start with bin_in = 13 -> no done for the aborted conversion; outputs zero after reset; second result 12'h013.
5. Parameters BIN_W = 8, DIGITS = 2: bin_in = 200 -> overflow = 1; bin_in = 99 -> bcd_out = 8'h99, overflow = 0.
6. With BIN2BCD_EX3_OUT_EN defined: after reset ex3_out = 12'h333; bin_in = 47 -> bcd_out = 12'h047, ex3_out = 12'h37A; bin_in = 255 -> ex3_out = 12'h588.
